// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the decode-stage register file.
package regfile_pkg;

  localparam int unsigned REG_DEPTH_DEF      = 32;
  localparam int unsigned REG_WIDTH_DEF      = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEF = $clog2(REG_DEPTH_DEF);

  typedef logic [REG_ADDR_WIDTH_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = REG_DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_nxt;

  // Set is applied after clear so a same-edge issue to the written register wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass and pending-write tracking.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned REG_DEPTH      = REG_DEPTH_DEF,
  parameter int unsigned REG_WIDTH      = REG_WIDTH_DEF,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned REG_ADDR_WIDTH = $clog2(REG_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]        wr_addr,
  input  logic [REG_WIDTH-1:0]             wr_data,
  input  logic                             iss_en,
  input  logic [REG_ADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_RD-1:0]                rd_use,
  output logic [NUM_RD*REG_WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  output logic                             stall
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [REG_WIDTH-1:0] regs [REG_DEPTH];
  logic [REG_DEPTH-1:0] busy;
  logic                 wr_ok;
  logic                 iss_ok;

  // Register 0 swallows both writes and issues when hardwired.
  assign wr_ok  = wr_en  && !(HAS_ZERO && (wr_addr  == ZERO_ADDR));
  assign iss_ok = iss_en && !(HAS_ZERO && (iss_addr == ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .DEPTH (REG_DEPTH),
    .AW    (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      port_data;
    logic                      port_busy;

    assign addr = rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

    // A bypassed value is never busy: any same-cycle issue belongs to a younger instruction.
    always_comb begin
      port_data = regs[addr];
      port_busy = busy[addr];
      if (HAS_ZERO && (addr == ZERO_ADDR)) begin
        port_data = '0;
        port_busy = 1'b0;
      end else if (wr_en && (wr_addr == addr)) begin
        port_data = wr_data;
        port_busy = 1'b0;
      end
    end

    assign rd_data[k*REG_WIDTH +: REG_WIDTH] = port_data;
    assign rd_busy[k]                        = port_busy;
  end

  assign stall = |(rd_use & rd_busy);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios then random traffic against an array model.
module tb_regfile_mp_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wr_en, iss_en;
  logic [AW-1:0]     wr_addr, iss_addr;
  logic [DW-1:0]     wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_use;
  logic [NR*DW-1:0]  rd_data_z0, rd_data_z1;
  logic [NR-1:0]     rd_busy_z0, rd_busy_z1;
  logic              stall_z0, stall_z1;

  regfile_mp_sb #(.REG_DEPTH(DEPTH), .REG_WIDTH(DW), .NUM_RD(NR), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data_z0), .rd_busy(rd_busy_z0), .stall(stall_z0)
  );

  regfile_mp_sb #(.REG_DEPTH(DEPTH), .REG_WIDTH(DW), .NUM_RD(NR), .ZERO_REG(1)) dut_z1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data_z1), .rd_busy(rd_busy_z1), .stall(stall_z1)
  );

  int tests = 0;
  int fails = 0;

  // Index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic          m_bsy [2][DEPTH];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] obs_data(input int inst, input int p);
    logic [NR*DW-1:0] v;
    v = (inst == 1) ? rd_data_z1 : rd_data_z0;
    return v[p*DW +: DW];
  endfunction

  function automatic logic obs_busy(input int inst, input int p);
    logic [NR-1:0] v;
    v = (inst == 1) ? rd_busy_z1 : rd_busy_z0;
    return v[p];
  endfunction

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      logic          es;
      logic [DW-1:0] ed;
      logic          eb;
      logic [AW-1:0] a;
      es = 1'b0;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        if (i == 1 && a == 0) begin
          ed = '0; eb = 1'b0;
        end else if (wr_en && wr_addr == a) begin
          ed = wr_data; eb = 1'b0;
        end else begin
          ed = m_mem[i][a]; eb = m_bsy[i][a];
        end
        es = es | (rd_use[p] & eb);
        chk($sformatf("z%0d_data_p%0d_r%0d", i, p, a), obs_data(i, p), ed);
        chk($sformatf("z%0d_busy_p%0d_r%0d", i, p, a), DW'(obs_busy(i, p)), DW'(eb));
      end
      chk($sformatf("z%0d_stall", i), DW'((i == 1) ? stall_z1 : stall_z0), DW'(es));
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int r = 0; r < DEPTH; r++) begin
          m_mem[i][r] = '0;
          m_bsy[i][r] = 1'b0;
        end
      end else begin
        if (wr_en && !(i == 1 && wr_addr == 0)) begin
          m_mem[i][wr_addr] = wr_data;
          m_bsy[i][wr_addr] = 1'b0;
        end
        if (iss_en && !(i == 1 && iss_addr == 0)) m_bsy[i][iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return '0;
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; iss_en = 1'b0;
    wr_addr = '0; iss_addr = '0; wr_data = '0; rd_addr = '0; rd_use = '0;
    tick();
    cycle();

    // Reset state on every register, every port
    idle();
    rd_use = '1;
    for (int r = 0; r < 11; r++) begin
      for (int p = 0; p < NR; p++) set_rd(p, AW'((3 * r + p) % DEPTH));
      settle();
      chk("reset_stall", DW'(stall_z1), '0);
      chk("reset_data_p2", obs_data(1, 2), '0);
      tick();
    end

    // Bypass then storage
    rd_use = '0;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
    settle();
    chk("bypass_r5", obs_data(1, 0), 32'hDEADBEEF);
    tick();
    idle();
    settle();
    chk("stored_r5", obs_data(1, 0), 32'hDEADBEEF);
    tick();

    // Issue r7, observe busy/stall, then clear through writeback
    iss_en = 1'b1; iss_addr = 7;
    cycle();
    idle();
    set_rd(1, 7); rd_use = 3'b010;
    settle();
    chk("busy_r7", DW'(rd_busy_z1[1]), 1);
    chk("stall_r7", DW'(stall_z1), 1);
    tick();
    cycle();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h0000_0777;
    settle();
    chk("wb_busy_r7", DW'(rd_busy_z1[1]), 0);
    chk("wb_stall_r7", DW'(stall_z1), 0);
    chk("wb_data_r7", obs_data(1, 1), 32'h0000_0777);
    tick();
    idle();
    cycle();

    // Same-edge issue and write to r9
    rd_use = '1;
    wr_en = 1'b1; iss_en = 1'b1; wr_addr = 9; iss_addr = 9; wr_data = 32'hA5A5_0009;
    set_rd(0, 9);
    settle();
    chk("same_edge_bypass_busy", DW'(rd_busy_z1[0]), 0);
    tick();
    idle();
    settle();
    chk("same_edge_data_r9", obs_data(1, 0), 32'hA5A5_0009);
    chk("same_edge_busy_r9", DW'(rd_busy_z1[0]), 1);
    chk("same_edge_stall", DW'(stall_z1), 1);
    tick();

    // Register 0 behaviour for both ZERO_REG settings
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h0000_1234; iss_en = 1'b1; iss_addr = 0;
    set_rd(0, 0);
    settle();
    chk("z1_r0_bypass", obs_data(1, 0), '0);
    chk("z0_r0_bypass", obs_data(0, 0), 32'h0000_1234);
    tick();
    idle();
    settle();
    chk("z1_r0_data", obs_data(1, 0), '0);
    chk("z1_r0_busy", DW'(rd_busy_z1[0]), 0);
    chk("z0_r0_data", obs_data(0, 0), 32'h0000_1234);
    chk("z0_r0_busy", DW'(rd_busy_z0[0]), 1);
    tick();

    // Reset mid-operation with r3 busy and a write/issue pending
    iss_en = 1'b1; iss_addr = 3;
    cycle();
    idle();
    set_rd(2, 3); rd_use = 3'b100;
    settle();
    chk("pre_rst_busy_r3", DW'(rd_busy_z1[2]), 1);
    tick();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_CAFE; iss_en = 1'b1; iss_addr = 3;
    cycle();
    idle();
    settle();
    chk("post_rst_data_r3", obs_data(1, 2), '0);
    chk("post_rst_busy_r3", DW'(rd_busy_z1[2]), 0);
    chk("post_rst_stall", DW'(stall_z1), 0);
    chk("post_rst_r9", DW'(m_bsy[1][9]), 0);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = rnd_addr();
      wr_data  = $urandom;
      iss_en   = $urandom_range(0, 2) == 0;
      iss_addr = rnd_addr();
      for (int p = 0; p < NR; p++) set_rd(p, rnd_addr());
      rd_use   = NR'($urandom_range(0, (1 << NR) - 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
